arith_ip_checker: RTL and testbench
===================================

Name: arith_ip_checker

Overview:
Hardware stimulus/response checker. It is the opposite end of the operand interface of the combinational arithmetic_ip block: it drives every M/A/B combination, samples S/Cout after a settle window, and compares each result against an internal golden model. It sits beside arithmetic_ip for on-chip self-test and reports the pass/fail status and the error count.

Parameters:
SETTLE_CYCLES, 2, number of wait cycles between driving a vector and sampling the DUT result; the legal range is 0..15.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  a one-cycle pulse that starts a sweep; sampled only in IDLE
A  output  2  operand A driven to the DUT (registered)
B  output  2  operand B driven to the DUT (registered)
M  output  2  mode driven to the DUT (registered)
S  input  3  result from the DUT
Cout  input  1  carry/flag from the DUT
Sr  input  3  secondary result from the DUT; not checked, ignored
busy  output  1  high from the cycle after the start edge until DONE is left
done  output  1  one-cycle pulse at the end of a sweep
pass  output  1  1 when the last completed sweep had err_count==0; held until the next start
err_count  output  7  number of mismatching vectors in the current or last sweep (0..64)
vec_count  output  7  number of vectors checked so far (0..64)

Behaviour:
- Reset values: A=B=M=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, FSM=IDLE, vector index=0.
- Reset mid-sweep aborts the sweep immediately. All outputs return to their reset values on the next edge.
- Vector index is 6 bits, {M,A,B}. B is innermost and M is outermost. Index 0..63, 64 vectors per sweep.
- Golden model (3-bit results, mod 8):
  - M=00: S=A+B, Cout=(A+B)>=4
  - M=01: S=A-B, Cout=(A>=B)
  - M=10: S=A+1, Cout=(A==3)
  - M=11: S=A-1, Cout=(A!=0)
- A vector mismatches if S or Cout differs from the golden model.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: when start=1, clear err_count, vec_count, pass and the index, then go to DRIVE.
- DRIVE (1 cycle): register {M,A,B}=index onto the outputs. Go to SETTLE, or straight to CHECK if SETTLE_CYCLES=0.
- SETTLE: stay for exactly SETTLE_CYCLES cycles, counted by a 4-bit counter, then go to CHECK.
- CHECK (1 cycle): compare the DUT result against the golden model and update counters:
  - vec_count +1
  - err_count +1 on mismatch
  - if index==63, go to DONE; otherwise increment the index and go to DRIVE.
- DONE (1 cycle): done=1, pass=(err_count==0), then go to IDLE. busy drops when DONE is left.
- A/B/M hold their last vector after the sweep ends.
- Per-vector time is SETTLE_CYCLES+2. done is high in cycle 64*(SETTLE_CYCLES+2)+1 after the start edge.
- start while busy, or in DONE, is ignored. It does not restart the sweep or alter the timing.
- start and rst in the same cycle: rst wins.
- err_count saturates naturally; it cannot exceed 64, so it needs no wrap logic.

Optional Feature:
ERR_LOG_EN
- Defined: adds outputs first_fail_idx[5:0], first_fail_S[2:0], first_fail_Cout and fail_seen.
- On the first mismatch of a sweep, these outputs capture the index and the DUT's S and Cout, and fail_seen goes to 1.
- Later mismatches do not overwrite the capture. The capture is cleared on start and on rst.
- Not defined: none of these ports or registers exist. Core behaviour and timing are identical.

Decomposition:
- Package arith_chk_pkg holds:
  - the FSM state enum
  - mode constants MODE_ADD, MODE_SUB, MODE_INC, MODE_DEC
  - NUM_VECTORS=64
  - the widths of the vector index and the counters
- One sub-module, arith_golden: a purely combinational golden model. Inputs are A, B, M; outputs are exp_S[2:0] and exp_Cout. It is instantiated once in arith_ip_checker.

Test Plan:
1. Correct DUT, SETTLE_CYCLES=2, start pulse -> busy goes high; done pulses in cycle 257; pass=1; err_count=0; vec_count=64.
2. DUT with Cout stuck at 0 -> err_count=32 (6 add, 10 sub, 4 inc, 12 dec); pass=0.
3. rst asserted in cycle 100 of a sweep -> all outputs are 0 next cycle; a new start then completes with pass=1 at the normal 257-cycle timing.
4. Extra start pulses in cycles 10 and 200 of a sweep -> ignored; done still in cycle 257; vec_count=64.
5. SETTLE_CYCLES=0, correct DUT -> done in cycle 129; pass=1.
6. ERR_LOG_EN defined, fault injected only at M=01,A=0,B=1 (DUT S=0) -> first_fail_idx=17, first_fail_S=0, fail_seen=1, err_count=1.

Source files
------------

// File: rtl/arith_chk_pkg.sv
// Shared types and constants for the arithmetic_ip self-test checker.
package arith_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } chk_state_t;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_INC = 2'b10;
  localparam logic [1:0] MODE_DEC = 2'b11;

  localparam int NUM_VECTORS = 64;
  localparam int IDX_W       = 6;
  localparam int CNT_W       = 7;
  localparam int SETTLE_W    = 4;

endpackage

// File: rtl/arith_golden.sv
// Combinational reference of arithmetic_ip: 3-bit results (mod 8) plus carry/flag.
module arith_golden
  import arith_chk_pkg::*;
(
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] M,
  output logic [2:0] exp_S,
  output logic       exp_Cout
);

  logic [2:0] a_ext;
  logic [2:0] b_ext;
  logic [2:0] sum;

  always_comb begin
    a_ext    = {1'b0, A};
    b_ext    = {1'b0, B};
    sum      = a_ext + b_ext;
    exp_S    = '0;
    exp_Cout = 1'b0;
    case (M)
      MODE_ADD: begin
        exp_S    = sum;
        exp_Cout = (sum >= 3'd4);
      end
      MODE_SUB: begin
        exp_S    = a_ext - b_ext;
        exp_Cout = (A >= B);
      end
      MODE_INC: begin
        exp_S    = a_ext + 3'd1;
        exp_Cout = (A == 2'd3);
      end
      default: begin
        exp_S    = a_ext - 3'd1;
        exp_Cout = (A != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/arith_ip_checker.sv
// Sweeps all 64 {M,A,B} vectors into arithmetic_ip and counts mismatches.
// Optional first-failure capture enabled by defining ERR_LOG_EN.
module arith_ip_checker
  import arith_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [1:0]       A,
  output logic [1:0]       B,
  output logic [1:0]       M,
  input  logic [2:0]       S,
  input  logic             Cout,
  input  logic [2:0]       Sr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count
`ifdef ERR_LOG_EN
  ,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_S,
  output logic             first_fail_Cout,
  output logic             fail_seen
`endif
);

  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;

  chk_state_t          state;
  chk_state_t          next_state;
  logic [IDX_W-1:0]    idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [2:0]          exp_S;
  logic                exp_Cout;
  logic                mismatch;
  logic                sr_unused;

  assign sr_unused = ^Sr;

  arith_golden u_golden (
    .A       (A),
    .B       (B),
    .M       (M),
    .exp_S   (exp_S),
    .exp_Cout(exp_Cout)
  );

  assign mismatch = (S != exp_S) || (Cout != exp_Cout);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_DRIVE;
      ST_DRIVE:  next_state = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) next_state = ST_CHECK;
      ST_CHECK:  next_state = (idx == IDX_LAST) ? ST_DONE : ST_DRIVE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      A          <= '0;
      B          <= '0;
      M          <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_count  <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            vec_count <= '0;
            pass      <= 1'b0;
          end
        end
        ST_DRIVE: begin
          {M, A, B}  <= idx;
          settle_cnt <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        ST_CHECK: begin
          vec_count <= vec_count + 1'b1;
          if (mismatch) err_count <= err_count + 1'b1;
          // Verdict is registered with the last check so it is valid alongside done.
          if (idx == IDX_LAST) pass <= (err_count == '0) && !mismatch;
          else                 idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE && start)) begin
      first_fail_idx  <= '0;
      first_fail_S    <= '0;
      first_fail_Cout <= 1'b0;
      fail_seen       <= 1'b0;
    end else if (state == ST_CHECK && mismatch && !fail_seen) begin
      first_fail_idx  <= idx;
      first_fail_S    <= S;
      first_fail_Cout <= Cout;
      fail_seen       <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arith_ip_checker.sv
// Scoreboard bench: two checkers (settle 2 and 0) against a faultable arithmetic_ip model.
module tb_arith_ip_checker;
  import arith_chk_pkg::*;

  typedef struct packed {
    int         done_cyc;
    int         err;
    int         vec;
    int         ffi;
    logic [2:0] ffs;
    logic       ffc;
    logic       fs;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst, start0, start1;
  logic [1:0] a0, b0, m0, a1, b1, m1;
  logic [2:0] s0, s1, sr0, sr1;
  logic       c0, c1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [6:0] err0, vec0, err1, vec1;
`ifdef ERR_LOG_EN
  logic [5:0] ffi0, ffi1;
  logic [2:0] ffs0, ffs1;
  logic       ffc0, ffc1, fs0, fs1;
`endif

  logic [2:0] xs [2][64];
  logic       xc [2][64];
  exp_t       q0[$];
  exp_t       q1[$];
  int         n_vec = 0;
  int         n_mis = 0;

  arith_ip_checker #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .M(m0),
    .S(s0), .Cout(c0), .Sr(sr0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .vec_count(vec0)
`ifdef ERR_LOG_EN
    , .first_fail_idx(ffi0), .first_fail_S(ffs0), .first_fail_Cout(ffc0), .fail_seen(fs0)
`endif
  );

  arith_ip_checker #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .M(m1),
    .S(s1), .Cout(c1), .Sr(sr1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_count(vec1)
`ifdef ERR_LOG_EN
    , .first_fail_idx(ffi1), .first_fail_S(ffs1), .first_fail_Cout(ffc1), .fail_seen(fs1)
`endif
  );

  // Reference arithmetic, straight from the mode definitions.
  function automatic logic [2:0] ref_s(input int m, input int a, input int b);
    int r;
    case (m)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a + 1;
      default: r = a - 1;
    endcase
    return 3'(r & 7);
  endfunction

  function automatic logic ref_c(input int m, input int a, input int b);
    case (m)
      0:       return (a + b) >= 4;
      1:       return a >= b;
      2:       return a == 3;
      default: return a != 0;
    endcase
  endfunction

  // Model of the device under self-test, with per-vector fault injection.
  always @(negedge clk) begin
    s0  <= ref_s(int'(m0), int'(a0), int'(b0)) ^ xs[0][{m0, a0, b0}];
    c0  <= ref_c(int'(m0), int'(a0), int'(b0)) ^ xc[0][{m0, a0, b0}];
    s1  <= ref_s(int'(m1), int'(a1), int'(b1)) ^ xs[1][{m1, a1, b1}];
    c1  <= ref_c(int'(m1), int'(a1), int'(b1)) ^ xc[1][{m1, a1, b1}];
    sr0 <= 3'($urandom);
    sr1 <= 3'($urandom);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t build_exp(input int inst, input int c_start, input int settle);
    exp_t e;
    e = '0;
    for (int i = 0; i < 64; i++) begin
      if (xs[inst][i] != 3'd0 || xc[inst][i] != 1'b0) begin
        if (e.err == 0) begin
          e.ffi = i;
          e.ffs = ref_s(i >> 4, (i >> 2) & 3, i & 3) ^ xs[inst][i];
          e.ffc = ref_c(i >> 4, (i >> 2) & 3, i & 3) ^ xc[inst][i];
          e.fs  = 1'b1;
        end
        e.err = e.err + 1;
      end
    end
    e.vec      = 64;
    e.pass     = (e.err == 0);
    e.done_cyc = c_start + 64 * (settle + 2);
    return e;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) check("spurious_done0", int'(done0), 0);
      else begin
        e = q0.pop_front();
        check("done_cycle0", cyc, e.done_cyc);
        check("pass0", int'(pass0), int'(e.pass));
        check("err_count0", int'(err0), e.err);
        check("vec_count0", int'(vec0), e.vec);
        check("busy_at_done0", int'(busy0), 1);
`ifdef ERR_LOG_EN
        check("fail_seen0", int'(fs0), int'(e.fs));
        if (e.fs) begin
          check("first_fail_idx0", int'(ffi0), e.ffi);
          check("first_fail_S0", int'(ffs0), int'(e.ffs));
          check("first_fail_Cout0", int'(ffc0), int'(e.ffc));
        end
`endif
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) check("spurious_done1", int'(done1), 0);
      else begin
        e = q1.pop_front();
        check("done_cycle1", cyc, e.done_cyc);
        check("pass1", int'(pass1), int'(e.pass));
        check("err_count1", int'(err1), e.err);
        check("vec_count1", int'(vec1), e.vec);
`ifdef ERR_LOG_EN
        check("fail_seen1", int'(fs1), int'(e.fs));
        if (e.fs) check("first_fail_idx1", int'(ffi1), e.ffi);
`endif
      end
    end
  end

  task automatic clear_faults(input int inst);
    for (int i = 0; i < 64; i++) begin
      xs[inst][i] = 3'd0;
      xc[inst][i] = 1'b0;
    end
  endtask

  task automatic random_faults(input int inst);
    int k, i;
    clear_faults(inst);
    k = $urandom_range(0, 5);
    for (int n = 0; n < k; n++) begin
      i = $urandom_range(0, 63);
      xs[inst][i] = 3'($urandom_range(0, 7));
      xc[inst][i] = 1'($urandom_range(0, 1));
      if (xs[inst][i] == 3'd0 && xc[inst][i] == 1'b0) xc[inst][i] = 1'b1;
    end
  endtask

  task automatic do_start(input int inst, output int s_cyc);
    @(negedge clk);
    if (inst == 0) start0 = 1'b1;
    else           start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    s_cyc  = cyc;
    if (inst == 0) begin
      q0.push_back(build_exp(0, s_cyc, 2));
      check("busy_after_start0", int'(busy0), 1);
    end else begin
      q1.push_back(build_exp(1, s_cyc, 0));
      check("busy_after_start1", int'(busy1), 1);
    end
  endtask

  task automatic wait_idle(input int inst, input int limit);
    int n = 0;
    while (((inst == 0) ? q0.size() : q1.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("sweep_timeout", (inst == 0) ? q0.size() : q1.size(), 0);
    if (inst == 0) q0.delete();
    else           q1.delete();
    @(negedge clk);
    check("busy_after_done", int'((inst == 0) ? busy0 : busy1), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    check("rst_abm0", int'({m0, a0, b0}), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_done0", int'(done0), 0);
    check("rst_pass0", int'(pass0), 0);
    check("rst_err0", int'(err0), 0);
    check("rst_vec0", int'(vec0), 0);
    check("rst_abm1", int'({m1, a1, b1}), 0);
`ifdef ERR_LOG_EN
    check("rst_fail_seen0", int'(fs0), 0);
`endif
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int s;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    clear_faults(0);
    clear_faults(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_busy0", int'(busy0), 0);
    check("init_pass0", int'(pass0), 0);
    check("init_err0", int'(err0), 0);
    check("init_vec0", int'(vec0), 0);
    check("init_abm0", int'({m0, a0, b0}), 0);

    // Clean sweep, settle 2.
    do_start(0, s);
    wait_idle(0, 400);
    check("pass_held0", int'(pass0), 1);

    // Cout stuck at 0.
    for (int i = 0; i < 64; i++) xc[0][i] = ref_c(i >> 4, (i >> 2) & 3, i & 3);
    do_start(0, s);
    wait_idle(0, 400);
    check("stuck_cout_err", int'(err0), 32);
    check("stuck_cout_pass", int'(pass0), 0);

    // Reset mid-sweep, then a normal sweep.
    clear_faults(0);
    do_start(0, s);
    while (cyc < s + 99) @(negedge clk);
    do_reset();
    do_start(0, s);
    wait_idle(0, 400);

    // Extra start pulses during the sweep are ignored.
    do_start(0, s);
    while (cyc < s + 9) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    while (cyc < s + 199) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_idle(0, 400);
    check("extra_start_vec", int'(vec0), 64);

    // Zero settle cycles.
    do_start(1, s);
    wait_idle(1, 300);

    // Single S fault at M=01,A=0,B=1 (index 17): DUT returns S=0.
    clear_faults(0);
    xs[0][17] = ref_s(1, 0, 1);
    do_start(0, s);
    wait_idle(0, 400);
    check("single_fault_err", int'(err0), 1);
`ifdef ERR_LOG_EN
    check("single_fault_idx", int'(ffi0), 17);
    check("single_fault_S", int'(ffs0), 0);
    check("single_fault_seen", int'(fs0), 1);
`endif

    // Randomised fault patterns on both checkers.
    for (int r = 0; r < 4; r++) begin
      random_faults(0);
      do_start(0, s);
      wait_idle(0, 400);
      random_faults(1);
      do_start(1, s);
      wait_idle(1, 300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
